aes_inv_cipher_iter: RTL and testbench

Iterative, multi-key-size AES inverse cipher core. It decrypts one 128-bit block per pass by looping a single non-last inverse round and a single last inverse round over a registered state, one round per clock. Round keys come from an external synchronous round-key memory (key expander or RAM) through an address/enable port. The core sits between the block-input valid/ready stream and the plaintext output valid/ready stream of the decipher path.

---
 rtl/aes_inv_cipher_iter_pkg.sv | 64 ++++++
 rtl/aes_inv_cipher_iter_round.sv | 34 +++
 rtl/aes_inv_cipher_iter.sv | 129 ++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_cipher_iter_pkg.sv
`default_nettype none
// ============================================================================
// aes_inv_cipher_iter_pkg : shared types and GF(2^8) helpers for the inverse cipher
// Revision: 1.0
// ============================================================================
package aes_inv_cipher_iter_pkg;

    localparam int DATA_WIDTH    = 128;
    localparam int RK_ADDR_W_MAX = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WHITEN = 3'd1,
        ROUND  = 3'd2,
        LAST   = 3'd3,
        DONE   = 3'd4
    } inv_fsm_t;

    function automatic int aes_nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Inverse affine map, then multiplicative inverse computed as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] r;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_iter_round.sv
`default_nettype none
// ============================================================================
// aes_inv_cipher_iter_round : one combinational AES inverse round
// Revision: 1.0
// ============================================================================
module aes_inv_cipher_iter_round
    import aes_inv_cipher_iter_pkg::*;
#(
    parameter bit LAST_ROUND = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] i_state,
    input  logic [DATA_WIDTH-1:0] i_rk,
    output logic [DATA_WIDTH-1:0] o_state
);

    logic [7:0] w_ak [16];

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // Byte at (row r, col c) comes from column c-r before the inverse shift.
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            localparam int DST = 4 * c + r;
            assign w_ak[DST] = inv_sbox(i_state[127-8*SRC -: 8]) ^ i_rk[127-8*DST -: 8];
        end
        if (LAST_ROUND) begin : g_last
            assign o_state[127-32*c -: 32] = {w_ak[4*c], w_ak[4*c+1], w_ak[4*c+2], w_ak[4*c+3]};
        end else begin : g_mix
            assign o_state[127-32*c -: 32] =
                inv_mix_col({w_ak[4*c], w_ak[4*c+1], w_ak[4*c+2], w_ak[4*c+3]});
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// aes_inv_cipher_iter : iterative AES-128/192/256 inverse cipher, one round per clock
// Revision: 1.0
// ============================================================================
module aes_inv_cipher_iter
    import aes_inv_cipher_iter_pkg::*;
#(
    parameter int KEY_BITS  = 128,
    parameter int RK_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  rk_en,
    output logic [RK_ADDR_W-1:0]  rk_addr,
    input  logic [DATA_WIDTH-1:0] rk_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    localparam int                   NR       = aes_nr(KEY_BITS);
    localparam logic [RK_ADDR_W-1:0] C_NR     = RK_ADDR_W'(NR);
    localparam logic [RK_ADDR_W-1:0] C_NR_M1  = RK_ADDR_W'(NR - 1);
    localparam logic [RK_ADDR_W-1:0] C_ONE    = RK_ADDR_W'(1);

    inv_fsm_t              r_fsm;
    logic [RK_ADDR_W-1:0]  r_ctr;
    logic [RK_ADDR_W-1:0]  r_rk_addr;
    logic [DATA_WIDTH-1:0] r_state;
    logic                  r_out_valid;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_round;
    logic [DATA_WIDTH-1:0] w_last;

    assign in_ready  = rst_n & ~flush & ((r_fsm == IDLE) | ((r_fsm == DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign busy      = (r_fsm != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_state;

    // Address leads the data by one cycle, so it is issued from the current state.
    always_comb begin
        rk_en   = 1'b0;
        rk_addr = r_rk_addr;
        if (w_accept) begin
            rk_en   = 1'b1;
            rk_addr = C_NR;
        end else if (r_fsm == WHITEN) begin
            rk_en   = 1'b1;
            rk_addr = C_NR_M1;
        end else if (r_fsm == ROUND) begin
            rk_en   = 1'b1;
            rk_addr = r_ctr - C_ONE;
        end
    end

    aes_inv_cipher_iter_round #(.LAST_ROUND(1'b0)) u_round (
        .i_state (r_state),
        .i_rk    (rk_data),
        .o_state (w_round)
    );

    aes_inv_cipher_iter_round #(.LAST_ROUND(1'b1)) u_last (
        .i_state (r_state),
        .i_rk    (rk_data),
        .o_state (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm       <= IDLE;
            r_ctr       <= '0;
            r_rk_addr   <= '0;
            r_state     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (rk_en) r_rk_addr <= rk_addr;
            if (flush) begin
                r_fsm       <= IDLE;
                r_out_valid <= 1'b0;
            end else begin
                case (r_fsm)
                    IDLE: begin
                        if (w_accept) begin
                            r_state <= in_data;
                            r_fsm   <= WHITEN;
                        end
                    end
                    WHITEN: begin
                        r_state <= r_state ^ rk_data;
                        r_ctr   <= C_NR_M1;
                        r_fsm   <= ROUND;
                    end
                    ROUND: begin
                        r_state <= w_round;
                        r_ctr   <= r_ctr - C_ONE;
                        if (r_ctr == C_ONE) r_fsm <= LAST;
                    end
                    LAST: begin
                        r_state     <= w_last;
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end
                    DONE: begin
                        // Consume and, if offered, start the next block in the same cycle.
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            if (w_accept) begin
                                r_state <= in_data;
                                r_fsm   <= WHITEN;
                            end else begin
                                r_fsm <= IDLE;
                            end
                        end
                    end
                    default: r_fsm <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// tb_aes_inv_cipher_iter : scoreboard bench, one core per key size against a forward-cipher model
// Revision: 1.0
// ============================================================================
module tb_aes_inv_cipher_iter;

    localparam int NI = 3;
    localparam logic [127:0] C_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk;
    logic         rst_n;
    logic         flush     [NI];
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [127:0] in_data   [NI];
    logic         rk_en     [NI];
    logic [3:0]   rk_addr   [NI];
    logic [127:0] rk_data   [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_data  [NI];
    logic         busy      [NI];

    logic [127:0] rk    [NI][16];
    logic [7:0]   sbox  [256];
    logic [127:0] exp_q [NI][$];
    int           lat_q [NI][$];
    int           exp_next [NI];
    bit           pend     [NI];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    bit           rnd_on;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        aes_inv_cipher_iter #(.KEY_BITS(128 + 64 * g), .RK_ADDR_W(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .rk_en     (rk_en[g]),
            .rk_addr   (rk_addr[g]),
            .rk_data   (rk_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
        always @(posedge clk) if (rk_en[g]) rk_data[g] <= rk[g][rk_addr[g]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int nr_of(int i);
        return 10 + 2 * i;
    endfunction

    function automatic logic [7:0] mul(logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(int inst, logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = 4 + 2 * inst;
        nr = nk + 6;
        rc = 8'h01;
        for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
        for (int j = nk; j < 4 * (nr + 1); j++) begin
            t = w[j-1];
            if (j % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = mul(rc, 8'h02);
            end else if (nk > 6 && j % nk == 4) begin
                t = subw(t);
            end
            w[j] = w[j-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[inst][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(int inst, logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        int nr;
        nr = nr_of(inst);
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rk[inst][0][127-8*n -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[4*c+w] = sbox[s[4*((c+w)%4)+w]];
            for (int c = 0; c < 4; c++) begin
                {a0, a1, a2, a3} = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
                if (r < nr) begin
                    s[4*c]   = mul(8'h02, a0) ^ mul(8'h03, a1) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ mul(8'h02, a1) ^ mul(8'h03, a2) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ mul(8'h02, a2) ^ mul(8'h03, a3);
                    s[4*c+3] = mul(8'h03, a0) ^ a1 ^ a2 ^ mul(8'h02, a3);
                end else begin
                    {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = {a0, a1, a2, a3};
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[inst][r][127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            exp_next[i] = -1;
            pend[i]     = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NI; i++) begin
                    if (out_valid[i]) begin
                        if (exp_q[i].size() == 0) begin
                            chk($sformatf("spurious_out_valid[%0d]", i), 128'd1, 128'd0);
                        end else begin
                            chk($sformatf("out_data[%0d]", i), out_data[i], exp_q[i][0]);
                            if (!pend[i]) begin
                                if (lat_q[i].size() == 0)
                                    chk($sformatf("latency_nosrc[%0d]", i), 128'd1, 128'd0);
                                else
                                    chk($sformatf("latency[%0d]", i), 128'(cyc - lat_q[i].pop_front()),
                                        128'(nr_of(i) + 2));
                            end
                            if (out_ready[i]) void'(exp_q[i].pop_front());
                        end
                    end
                    pend[i] = out_valid[i] && !out_ready[i];
                    if (in_valid[i] && in_ready[i]) begin
                        lat_q[i].push_back(cyc);
                        exp_next[i] = nr_of(i);
                    end
                    if (rk_en[i]) begin
                        chk($sformatf("rk_addr[%0d]", i), 128'(rk_addr[i]), 128'(signed'(exp_next[i])));
                        exp_next[i]--;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(int i, logic [127:0] ct, logic [127:0] pt, output int waited);
        in_valid[i] = 1'b1;
        in_data[i]  = ct;
        waited      = 0;
        forever begin
            @(negedge clk);
            if (in_ready[i] || waited > 100) break;
            waited++;
        end
        if (in_ready[i]) exp_q[i].push_back(pt);
        else chk($sformatf("accept_timeout[%0d]", i), 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic send_rand(int i);
        logic [127:0] pt;
        int w;
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(i, encrypt(i, pt), pt, w);
    endtask

    task automatic wait_valid(int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[i] && n < 60);
        if (!out_valid[i]) chk($sformatf("out_valid_timeout[%0d]", i), 128'd0, 128'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb(int i);
        exp_q[i].delete();
        lat_q[i].delete();
        exp_next[i] = -1;
    endtask

    task automatic run_random(int i, int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_rand(i);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int w0, w1, w2, wb;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            flush[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
        end
        build_sbox();

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
            chk("rst_out_data", out_data[i], 128'd0);
            chk("rst_rk_en", 128'(rk_en[i]), 128'd0);
            chk("rst_rk_addr", 128'(rk_addr[i]), 128'd0);
            chk("rst_busy", 128'(busy[i]), 128'd0);
            chk("rst_in_ready", 128'(in_ready[i]), 128'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 128'(in_ready[0]), 128'd1);
        @(posedge clk);
        #1;

        // Known-answer blocks for all three key sizes in parallel.
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        fork
            send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, C_PT, w0);
            send(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, C_PT, w1);
            send(2, 128'h8ea2b7ca516745bfeafc49904b496089, C_PT, w2);
        join
        drain();

        // Random keys and blocks with random downstream backpressure.
        for (int i = 0; i < NI; i++)
            expand(i, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        rnd_on = 1'b1;
        fork
            begin
                fork
                    run_random(0, 10);
                    run_random(1, 10);
                    run_random(2, 10);
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < NI; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        for (int i = 0; i < NI; i++) out_ready[i] = 1'b1;
        drain();

        // Hold output for 5 cycles, then consume and accept the next block together.
        out_ready[0] = 1'b0;
        send_rand(0);
        wait_valid(0);
        chk("in_ready_while_held", 128'(in_ready[0]), 128'd0);
        repeat (5) @(posedge clk);
        #1 out_ready[0] = 1'b1;
        send_rand_b2b: begin
            logic [127:0] pt;
            pt = {$urandom, $urandom, $urandom, $urandom};
            send(0, encrypt(0, pt), pt, wb);
        end
        chk("b2b_accept_wait", 128'(wb), 128'd0);
        drain();

        // Flush in cycle 5 of a block.
        send_rand(0);
        repeat (4) @(posedge clk);
        #1 flush[0] = 1'b1;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        clear_sb(0);
        @(negedge clk);
        chk("flush_busy", 128'(busy[0]), 128'd0);
        chk("flush_out_valid", 128'(out_valid[0]), 128'd0);
        chk("flush_rk_en", 128'(rk_en[0]), 128'd0);
        @(posedge clk);
        #1 send_rand(0);
        drain();

        // Flush while an output is pending.
        out_ready[0] = 1'b0;
        send_rand(0);
        wait_valid(0);
        @(posedge clk);
        #1 flush[0] = 1'b1;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        out_ready[0] = 1'b1;
        clear_sb(0);
        @(negedge clk);
        chk("flush_done_out_valid", 128'(out_valid[0]), 128'd0);
        chk("flush_done_busy", 128'(busy[0]), 128'd0);
        @(posedge clk);
        #1;

        // One-cycle reset in the middle of a block.
        send_rand(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("in_ready_during_rst", 128'(in_ready[0]), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NI; i++) clear_sb(i);
        @(negedge clk);
        chk("mid_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("mid_rst_out_data", out_data[0], 128'd0);
        chk("mid_rst_rk_en", 128'(rk_en[0]), 128'd0);
        chk("mid_rst_rk_addr", 128'(rk_addr[0]), 128'd0);
        chk("mid_rst_busy", 128'(busy[0]), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'd1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 send_rand(0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
